// File: rtl/axi4lite_reg_station_fifo.sv
`default_nettype none
// ============================================================================
// axi4lite_reg_station_fifo
// Five-channel AXI4-Lite register station: one FIFO per channel, an
// outstanding-transaction limiter for each direction, and a SLVERR override
// on responses.
// Revision: 1.0
// ============================================================================

module axi4lite_reg_station_fifo_chan #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;

  // Readiness comes only from the registered count, never from in_valid.
  assign in_ready  = enable && (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module axi4lite_reg_station_fifo #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              err_write_i,
  input  logic                              err_read_i,
  input  logic [ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [DATA_WIDTH-1:0]             s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam int AW_W = ADDR_WIDTH + 3;
  localparam int WD_W = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int RD_W = DATA_WIDTH + 2;

  logic          ready_en;
  logic [CW-1:0] wr_out;
  logic [CW-1:0] rd_out;
  logic          wr_ok, rd_ok;
  logic          aw_fifo_ready, ar_fifo_ready;
  logic          aw_hs, b_hs, ar_hs, r_hs;
  logic [1:0]    b_in, r_resp_in;

  // Holds every ready low until the first clock edge after reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign wr_ok = (wr_out < MAX_CNT);
  assign rd_ok = (rd_out < MAX_CNT);
  assign s_axi_awready = aw_fifo_ready && wr_ok;
  assign s_axi_arready = ar_fifo_ready && rd_ok;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign b_in      = err_write_i ? 2'b10 : m_axi_bresp;
  assign r_resp_in = err_read_i  ? 2'b10 : m_axi_rresp;

  axi4lite_reg_station_fifo_chan #(.W(AW_W), .DEPTH(DEPTH)) u_aw (
    .clk(aclk), .rst(areset), .enable(ready_en),
    .in_valid(s_axi_awvalid && wr_ok), .in_data({s_axi_awprot, s_axi_awaddr}),
    .in_ready(aw_fifo_ready),
    .out_valid(m_axi_awvalid), .out_data({m_axi_awprot, m_axi_awaddr}),
    .out_ready(m_axi_awready)
  );

  axi4lite_reg_station_fifo_chan #(.W(WD_W), .DEPTH(DEPTH)) u_w (
    .clk(aclk), .rst(areset), .enable(ready_en),
    .in_valid(s_axi_wvalid), .in_data({s_axi_wstrb, s_axi_wdata}),
    .in_ready(s_axi_wready),
    .out_valid(m_axi_wvalid), .out_data({m_axi_wstrb, m_axi_wdata}),
    .out_ready(m_axi_wready)
  );

  axi4lite_reg_station_fifo_chan #(.W(2), .DEPTH(DEPTH)) u_b (
    .clk(aclk), .rst(areset), .enable(ready_en),
    .in_valid(m_axi_bvalid), .in_data(b_in), .in_ready(m_axi_bready),
    .out_valid(s_axi_bvalid), .out_data(s_axi_bresp), .out_ready(s_axi_bready)
  );

  axi4lite_reg_station_fifo_chan #(.W(AW_W), .DEPTH(DEPTH)) u_ar (
    .clk(aclk), .rst(areset), .enable(ready_en),
    .in_valid(s_axi_arvalid && rd_ok), .in_data({s_axi_arprot, s_axi_araddr}),
    .in_ready(ar_fifo_ready),
    .out_valid(m_axi_arvalid), .out_data({m_axi_arprot, m_axi_araddr}),
    .out_ready(m_axi_arready)
  );

  axi4lite_reg_station_fifo_chan #(.W(RD_W), .DEPTH(DEPTH)) u_r (
    .clk(aclk), .rst(areset), .enable(ready_en),
    .in_valid(m_axi_rvalid), .in_data({r_resp_in, m_axi_rdata}),
    .in_ready(m_axi_rready),
    .out_valid(s_axi_rvalid), .out_data({s_axi_rresp, s_axi_rdata}),
    .out_ready(s_axi_rready)
  );

  // A retire in the same cycle as an accept leaves the count unchanged.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_out <= '0;
      rd_out <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wr_out <= wr_out + CW'(1);
        2'b01:   wr_out <= wr_out - CW'(1);
        default: wr_out <= wr_out;
      endcase
      case ({ar_hs, r_hs})
        2'b10:   rd_out <= rd_out + CW'(1);
        2'b01:   rd_out <= rd_out - CW'(1);
        default: rd_out <= rd_out;
      endcase
    end
  end

  assign wr_outstanding_o = wr_out;
  assign rd_outstanding_o = rd_out;
endmodule

`default_nettype wire
